output_buffer_fifo: RTL and testbench

Parametrised successor to the single-cycle MIPS output register block. It holds a write-addressable bank of output registers with address 0 hardwired to zero, and a registered read-back port. An "out" strobe no longer drives one output register. Instead it enqueues the addressed word into a FIFO, which drains to an external consumer (display/UART) over a valid/ready handshake. Overflow and occupancy status are reported to the CPU side.

---
 rtl/output_buffer_fifo_if.sv | 66 ++++++
 rtl/output_buffer_fifo.sv | 141 ++++++++++++++
 tb/tb_output_buffer_fifo.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/output_buffer_fifo_if.sv
// ============================================================================
// Module      : output_buffer_fifo_if
// Description : CPU-side register/strobe bus and consumer-side FIFO handshake
//               for output_buffer_fifo.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface output_buffer_fifo_if #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 8
);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   // CPU side
   logic              mem_write;
   logic              out;
   logic [ADDR_W-1:0] address;
   logic [DATA_W-1:0] writedata;
   logic [DATA_W-1:0] rdata;
   logic              clr_ovf;
   logic [CNT_W-1:0]  fifo_count;
   logic              fifo_full;
   logic              fifo_empty;
   logic              overflow;

   // Consumer side
   logic [DATA_W-1:0] out_data;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output mem_write,
      output out,
      output address,
      output writedata,
      output clr_ovf,
      output out_ready,
      input  rdata,
      input  fifo_count,
      input  fifo_full,
      input  fifo_empty,
      input  overflow,
      input  out_data,
      input  out_valid
   );

   modport slave (
      input  mem_write,
      input  out,
      input  address,
      input  writedata,
      input  clr_ovf,
      input  out_ready,
      output rdata,
      output fifo_count,
      output fifo_full,
      output fifo_empty,
      output overflow,
      output out_data,
      output out_valid
   );
endinterface

`default_nettype wire

// File: rtl/output_buffer_fifo.sv
// ============================================================================
// Module      : output_buffer_fifo
// Description : Write-addressable output register bank (address 0 reads zero)
//               with registered read-back, feeding a first-word-fall-through
//               FIFO drained over a valid/ready handshake.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module output_buffer_fifo #(
   parameter int DATA_W     = 32,
   parameter int ADDR_W     = 5,
   parameter int FIFO_DEPTH = 8
) (
   input wire                  clock,
   input wire                  rst,
   output_buffer_fifo_if.slave bus
);
   localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1;
   localparam int c_PTR_W      = $clog2(FIFO_DEPTH);
   localparam int c_BANK_DEPTH = 2 ** ADDR_W;

   // ------------------------------------------------------------------------
   // Register bank
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0] w_bank [c_BANK_DEPTH];
   logic [DATA_W-1:0] w_bank_rd;
   logic              w_addr_nz;
   logic              w_bank_we;
   logic [DATA_W-1:0] r_rdata;

   assign w_addr_nz = (bus.address != '0);
   assign w_bank_we = bus.mem_write && w_addr_nz;

   genvar gi;
   generate
      for (gi = 0; gi < c_BANK_DEPTH; gi++) begin : g_bank
         if (gi == 0) begin : g_zero
            assign w_bank[gi] = '0;
         end else begin : g_word
            logic [DATA_W-1:0] r_word;

            always_ff @(posedge clock) begin
               if (rst) begin
                  r_word <= '0;
               end else if (w_bank_we && (bus.address == ADDR_W'(gi))) begin
                  r_word <= bus.writedata;
               end
            end

            assign w_bank[gi] = r_word;
         end
      end
   endgenerate

   assign w_bank_rd = w_bank[bus.address];

   // Read-first: the bank word sampled here is the pre-write value.
   always_ff @(posedge clock) begin
      if (rst) begin
         r_rdata <= '0;
      end else begin
         r_rdata <= w_bank_rd;
      end
   end

   assign bus.rdata = r_rdata;

   // ------------------------------------------------------------------------
   // Output FIFO
   // ------------------------------------------------------------------------
   logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
   logic [c_PTR_W-1:0] r_wr_ptr;
   logic [c_PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0]   r_count;
   logic               r_overflow;

   logic               w_empty;
   logic               w_full;
   logic               w_pop;
   logic               w_push;
   logic               w_drop;
   logic [DATA_W-1:0]  w_push_data;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_pop   = !w_empty && bus.out_ready;

   // A pop in the same cycle frees a slot, so a full FIFO still accepts.
   assign w_push  = bus.out && (!w_full || w_pop);
   assign w_drop  = bus.out && w_full && !w_pop;

   assign w_push_data = w_bank_we ? bus.writedata : w_bank_rd;

   always_ff @(posedge clock) begin
      if (w_push && !rst) begin
         r_mem[r_wr_ptr] <= w_push_data;
      end
   end

   always_ff @(posedge clock) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // A dropped enqueue wins over a simultaneous clear.
   always_ff @(posedge clock) begin
      if (rst) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (bus.clr_ovf) begin
         r_overflow <= 1'b0;
      end
   end

   assign bus.out_data   = w_empty ? '0 : r_mem[r_rd_ptr];
   assign bus.out_valid  = !w_empty;
   assign bus.fifo_count = r_count;
   assign bus.fifo_full  = w_full;
   assign bus.fifo_empty = w_empty;
   assign bus.overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_output_buffer_fifo.sv
// ============================================================================
// Module      : tb_output_buffer_fifo
// Description : Directed and randomized bench for output_buffer_fifo against a
//               queue-based reference model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_output_buffer_fifo;
   localparam int DATA_W     = 32;
   localparam int ADDR_W     = 5;
   localparam int FIFO_DEPTH = 8;

   logic clock = 1'b0;
   logic rst   = 1'b1;

   output_buffer_fifo_if #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) bus ();

   output_buffer_fifo #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clock (clock),
      .rst   (rst),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   int n_compared   = 0;
   int n_mismatched = 0;

   // Reference model state
   logic [DATA_W-1:0] m_bank [2**ADDR_W];
   logic [DATA_W-1:0] m_q [$];
   logic              m_ovf;
   logic [DATA_W-1:0] m_rdata;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_compared++;
      if (got !== exp) begin
         n_mismatched++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
      end
   endtask

   // One clock: drive inputs, advance the model, compare every output after the edge.
   task automatic step(input logic r, input logic we, input logic o,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] wd,
                       input logic rdy, input logic clr);
      logic              pop;
      logic              full;
      logic [DATA_W-1:0] pv;
      rst           = r;
      bus.mem_write = we;
      bus.out       = o;
      bus.address   = a;
      bus.writedata = wd;
      bus.out_ready = rdy;
      bus.clr_ovf   = clr;

      if (r) begin
         for (int i = 0; i < 2**ADDR_W; i++) m_bank[i] = '0;
         m_q.delete();
         m_ovf   = 1'b0;
         m_rdata = '0;
      end else begin
         pop     = (m_q.size() > 0) && rdy;
         full    = (m_q.size() == FIFO_DEPTH);
         pv      = (we && a != 0) ? wd : m_bank[a];
         m_rdata = m_bank[a];
         if (pop) void'(m_q.pop_front());
         if (o && (!full || pop)) m_q.push_back(pv);
         if (o && full && !pop) m_ovf = 1'b1;
         else if (clr)          m_ovf = 1'b0;
         if (we && a != 0) m_bank[a] = wd;
      end

      @(posedge clock);
      #1;
      check_eq("rdata",      bus.rdata,      m_rdata);
      check_eq("out_valid",  bus.out_valid,  m_q.size() > 0);
      check_eq("out_data",   bus.out_data,   (m_q.size() > 0) ? m_q[0] : '0);
      check_eq("fifo_count", bus.fifo_count, m_q.size());
      check_eq("fifo_full",  bus.fifo_full,  m_q.size() == FIFO_DEPTH);
      check_eq("fifo_empty", bus.fifo_empty, m_q.size() == 0);
      check_eq("overflow",   bus.overflow,   m_ovf);
   endtask

   initial begin
      bus.mem_write = 1'b0;
      bus.out       = 1'b0;
      bus.address   = '0;
      bus.writedata = '0;
      bus.out_ready = 1'b0;
      bus.clr_ovf   = 1'b0;

      step(1, 0, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0, 0);
      check_eq("reset_valid", bus.out_valid, 0);
      check_eq("reset_empty", bus.fifo_empty, 1);

      // Bank write and read-back; address 0 stays zero
      step(0, 1, 0, 3, 32'hDEADBEEF, 0, 0);
      step(0, 1, 0, 0, 32'h12345678, 0, 0);
      step(0, 0, 0, 3, 0, 0, 0);
      check_eq("rd_addr3", bus.rdata, 32'hDEADBEEF);
      step(0, 0, 0, 0, 0, 0, 0);
      check_eq("rd_addr0", bus.rdata, 0);

      // Single enqueue then drain
      step(0, 1, 0, 5, 32'hA5A5A5A5, 0, 0);
      step(0, 0, 1, 5, 0, 0, 0);
      check_eq("enq_valid", bus.out_valid, 1);
      check_eq("enq_data",  bus.out_data, 32'hA5A5A5A5);
      check_eq("enq_count", bus.fifo_count, 1);
      step(0, 0, 0, 5, 0, 1, 0);
      check_eq("deq_valid", bus.out_valid, 0);
      check_eq("deq_data",  bus.out_data, 0);

      // Write bypass into the FIFO
      step(0, 1, 1, 7, 32'h42, 0, 0);
      check_eq("bypass_head", bus.out_data, 32'h42);
      step(0, 0, 0, 7, 0, 1, 0);
      check_eq("bypass_rd", bus.rdata, 32'h42);

      // Fill past capacity, drain in order, clear overflow
      for (int k = 1; k <= 9; k++) begin
         step(0, 1, 1, 1, DATA_W'(k), 0, 0);
         if (k == 8) check_eq("full_at_8", bus.fifo_full, 1);
         if (k == 8) check_eq("no_ovf_at_8", bus.overflow, 0);
      end
      check_eq("ovf_at_9", bus.overflow, 1);
      for (int k = 1; k <= 8; k++) begin
         check_eq("drain_order", bus.out_data, DATA_W'(k));
         step(0, 0, 0, 1, 0, 1, 0);
      end
      check_eq("drained_empty", bus.fifo_empty, 1);
      step(0, 0, 0, 1, 0, 0, 1);
      check_eq("ovf_cleared", bus.overflow, 0);

      // Push while full with a simultaneous pop; pointer wrap
      for (int k = 1; k <= 8; k++) step(0, 1, 1, 2, DATA_W'(100 + k), 0, 0);
      step(0, 1, 1, 2, 200, 1, 0);
      check_eq("full_pp_count", bus.fifo_count, 8);
      check_eq("full_pp_head",  bus.out_data, 102);
      check_eq("full_pp_ovf",   bus.overflow, 0);
      for (int i = 0; i < 20; i++) step(0, 1, 1, 2, DATA_W'(300 + i), 1, 0);
      check_eq("wrap_count", bus.fifo_count, 8);
      check_eq("wrap_head",  bus.out_data, 312);
      for (int k = 0; k < 8; k++) step(0, 0, 0, 2, 0, 1, 0);

      // Reset mid-drain with overflow pending
      for (int k = 1; k <= 9; k++) step(0, 1, 1, 4, DATA_W'(k * 11), 0, 0);
      for (int k = 0; k < 5; k++) step(0, 0, 0, 4, 0, (k % 2) == 0, 0);
      check_eq("pre_rst_count", bus.fifo_count, 5);
      step(1, 1, 1, 4, 32'hFFFF0000, 1, 0);
      check_eq("rst_count", bus.fifo_count, 0);
      check_eq("rst_valid", bus.out_valid, 0);
      check_eq("rst_ovf",   bus.overflow, 0);
      for (int a = 0; a < 8; a++) begin
         step(0, 0, 0, ADDR_W'(a), 0, 0, 0);
         check_eq("rst_bank", bus.rdata, 0);
      end

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         step(($urandom % 150) == 0,
              ($urandom % 3) == 0,
              ($urandom % 2) == 0,
              ADDR_W'($urandom_range(0, 7)),
              $urandom,
              ($urandom % 3) == 0,
              ($urandom % 20) == 0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end
endmodule

`default_nettype wire
